// File: rtl/booth_pkg.sv
// Shared types and Booth digit encoding for the radix-4 sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    R4_Idle,
    R4_Recode,
    R4_AddWait,
    R4_Done
  } BoothR4State;

  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] PM1  = 3'd1;
  localparam logic [2:0] PM2  = 3'd2;
  localparam logic [2:0] NM1  = 3'd3;
  localparam logic [2:0] NM2  = 3'd4;

  // Radix-4 recoding of the overlapping triplet {q[1], q[0], q_minus_1}.
  function automatic logic [2:0] booth_digit(input logic [2:0] bits);
    logic [2:0] d;
    case (bits)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = PM1;
      3'b011:         d = PM2;
      3'b100:         d = NM2;
      default:        d = NM1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Combinational Booth digit recoder: turns the current multiplier triplet and
// the extended multiplicand into the digit code and the AW-bit adder operand.
module booth_r4_recode
  import booth_pkg::*;
#(
  parameter int XW = 26,
  parameter int AW = 28
) (
  input  logic [2:0]    i_bits,
  input  logic [XW-1:0] i_m,
  output logic [2:0]    o_digit,
  output logic [AW-1:0] o_operand
);

  logic [AW-1:0] w_m1;
  logic [AW-1:0] w_m2;

  assign w_m1 = {{(AW-XW){i_m[XW-1]}}, i_m};
  assign w_m2 = {w_m1[AW-2:0], 1'b0};

  always_comb begin
    o_digit   = booth_digit(i_bits);
    o_operand = '0;
    case (o_digit)
      PM1:     o_operand = w_m1;
      PM2:     o_operand = w_m2;
      NM1:     o_operand = ~w_m1 + AW'(1);
      NM2:     o_operand = ~w_m2 + AW'(1);
      default: o_operand = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier; every nonzero partial product is added
// through the shared external adder over a valid/ack handshake.
//
// state      | meaning
// R4_Idle    | waiting for BREQ; operands latched on accept
// R4_Recode  | recode next digit; zero digit shifts now, else issue adder request
// R4_AddWait | adder request held until Adder_ack, then accumulate and shift
// R4_Done    | result registered, BACK high for this single cycle
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 24,
  localparam int XW   = WIDTH + 2,
  localparam int AW   = WIDTH + 4,
  localparam int ITER = XW / 2,
  localparam int CW   = $clog2(ITER + 1)
) (
  input  logic               CLK,
  input  logic               RSTK,
  input  logic               BREQ,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   m1,
  input  logic [WIDTH-1:0]   m2,
  output logic [2*WIDTH-1:0] res,
  output logic [1:0]         res_exc,
  output logic               BACK,
  output logic               busy,
  output logic [AW-1:0]      Adder_datain1,
  output logic [AW-1:0]      Adder_datain2,
  output logic               Adder_valid,
  input  logic [AW-1:0]      Adder_dataout,
  input  logic               Adder_carryout,
  input  logic [1:0]         Adder_Exc,
  input  logic               Adder_ack
);

  localparam int SW = AW + XW + 1;

  BoothR4State r_state;
  BoothR4State w_state_nx;

  logic [AW-1:0]      r_a;
  logic [XW-1:0]      r_q;
  logic               r_q1;
  logic [XW-1:0]      r_m;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_exc_acc;
  logic [2*WIDTH-1:0] r_res;
  logic [1:0]         r_res_exc;
  logic [AW-1:0]      r_din1;
  logic [AW-1:0]      r_din2;

  logic [2:0]    w_digit;
  logic [AW-1:0] w_operand;
  logic [AW-1:0] w_src_a;
  logic [SW-1:0] w_cat;
  logic [SW-1:0] w_sh;
  logic [AW-1:0] w_a_nx;
  logic [XW-1:0] w_q_nx;
  logic          w_q1_nx;
  logic [CW-1:0] w_count_inc;
  logic          w_last;
  logic          w_ack_take;
  logic          w_shift_en;
  logic [1:0]    w_exc_in;
  logic [XW-1:0] w_m1_ext;
  logic [XW-1:0] w_m2_ext;
  logic          w_unused_carry;

  assign w_unused_carry = Adder_carryout;

  booth_r4_recode #(
    .XW(XW),
    .AW(AW)
  ) u_recode (
    .i_bits   ({r_q[1:0], r_q1}),
    .i_m      (r_m),
    .o_digit  (w_digit),
    .o_operand(w_operand)
  );

  assign w_m1_ext = {{2{signed_mode & m1[WIDTH-1]}}, m1};
  assign w_m2_ext = {{2{signed_mode & m2[WIDTH-1]}}, m2};

  assign w_ack_take  = (r_state == R4_AddWait) && Adder_ack;
  assign w_shift_en  = ((r_state == R4_Recode) && (w_digit == ZERO)) || w_ack_take;
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (w_count_inc == CW'(ITER));
  assign w_exc_in    = w_ack_take ? Adder_Exc : 2'b00;

  // The sum is folded into the shift on the same edge it is accepted.
  assign w_src_a = w_ack_take ? Adder_dataout : r_a;
  assign w_cat   = {w_src_a, r_q, r_q1};
  assign w_sh    = {{2{w_cat[SW-1]}}, w_cat[SW-1:2]};
  assign w_a_nx  = w_sh[SW-1 -: AW];
  assign w_q_nx  = w_sh[XW:1];
  assign w_q1_nx = w_sh[0];

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) r_state <= R4_Idle;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      R4_Idle:    if (BREQ) w_state_nx = R4_Recode;
      R4_Recode:  begin
        if (w_digit != ZERO) w_state_nx = R4_AddWait;
        else if (w_last)     w_state_nx = R4_Done;
      end
      R4_AddWait: if (Adder_ack) w_state_nx = w_last ? R4_Done : R4_Recode;
      R4_Done:    w_state_nx = R4_Idle;
      default:    w_state_nx = R4_Idle;
    endcase
  end

  always_comb begin
    BACK        = (r_state == R4_Done);
    busy        = (r_state != R4_Idle);
    Adder_valid = (r_state == R4_AddWait);
  end

  always_ff @(posedge CLK or posedge RSTK) begin
    if (RSTK) begin
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_exc_acc <= 2'b00;
      r_res     <= '0;
      r_res_exc <= 2'b00;
      r_din1    <= '0;
      r_din2    <= '0;
    end else begin
      if ((r_state == R4_Idle) && BREQ) begin
        r_m       <= w_m1_ext;
        r_q       <= w_m2_ext;
        r_a       <= '0;
        r_q1      <= 1'b0;
        r_count   <= '0;
        r_exc_acc <= 2'b00;
      end
      if ((r_state == R4_Recode) && (w_digit != ZERO)) begin
        r_din1 <= r_a;
        r_din2 <= w_operand;
      end
      if (w_shift_en) begin
        r_a       <= w_a_nx;
        r_q       <= w_q_nx;
        r_q1      <= w_q1_nx;
        r_count   <= w_count_inc;
        r_exc_acc <= r_exc_acc | w_exc_in;
        if (w_last) begin
          r_res     <= {w_a_nx[2*WIDTH-XW-1:0], w_q_nx};
          r_res_exc <= r_exc_acc | w_exc_in;
        end
      end
    end
  end

  assign res           = r_res;
  assign res_exc       = r_res_exc;
  assign Adder_datain1 = r_din1;
  assign Adder_datain2 = r_din2;

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
- Parametrised radix-4 Booth sequential multiplier. Successor to the 24-bit radix-2 Booth unit in the FPU mantissa path.
- Signed or unsigned operands of any even WIDTH. Roughly half the iterations of radix-2.
- Zero Booth digits skip the adder entirely.
- All additions go through the shared external adder over the existing valid/ack callee interface. Adder exceptions are reported alongside the result.

Parameters:
- WIDTH, 24, operand width; must be even and ≥ 4.
- XW, WIDTH+2, internal extended operand width (derived).
- AW, WIDTH+4, accumulator and adder datapath width (derived).
- ITER, XW/2, number of Booth iterations; 13 at default (derived).

Ports:
- CLK  in  1  clock, rising edge.
- RSTK  in  1  reset, asynchronous, active-high.
- BREQ  in  1  start request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with BREQ.
- m1  in  WIDTH  multiplicand; sampled with BREQ.
- m2  in  WIDTH  multiplier; sampled with BREQ.
- res  out  2*WIDTH  product; registered, holds until the next completion.
- res_exc  out  2  OR of all Adder_Exc values seen during the operation; updates with res.
- BACK  out  1  one-cycle completion pulse.
- busy  out  1  high from BREQ acceptance until the cycle BACK is high, inclusive.
- Adder_datain1  out  AW  accumulator operand.
- Adder_datain2  out  AW  selected ±M/±2M operand.
- Adder_valid  out  1  adder request.
- Adder_dataout  in  AW  sum.
- Adder_carryout  in  1  ignored.
- Adder_Exc  in  2  adder exception code.
- Adder_ack  in  1  sum valid.

Behaviour:
- Reset (async, any state): state = IDLE; A, Q, Q1, M, count = 0; res, res_exc, BACK, busy, Adder_valid, Adder_datain1/2 = 0. An operation in flight is abandoned, Adder_valid drops immediately, and no BACK is produced.
- Operand extension:
  - M = m1 sign-extended (signed_mode=1) or zero-extended (0) to XW.
  - Q = m2 extended the same way.
  - A = 0, Q1 = 0, count = 0, res_exc = 0.
- IDLE:
  - BREQ=1 at an edge: latch operands, go to RECODE, busy=1.
  - BREQ while not in IDLE is ignored; there is no queueing.
- RECODE: compute digit d from {Q[1:0],Q1}.
  - 000 and 111 give 0.
  - 001 and 010 give +M.
  - 011 gives +2M.
  - 100 gives −2M.
  - 101 and 110 give −M.
  - All values are sign-extended to AW; negation is two's complement.
  - d=0: shift this edge ({A,Q,Q1} arithmetic shift right by 2), count++; no adder traffic.
  - d≠0: register Adder_valid=1, Adder_datain1=A, Adder_datain2=operand; go to ADD_WAIT.
- ADD_WAIT:
  - Adder_valid and data held stable until Adder_ack=1 is sampled.
  - On that edge: A ← Adder_dataout, then shift {Adder_dataout,Q,Q1} by 2 in the same edge; count++; Adder_valid ← 0; res_exc |= Adder_Exc.
  - No timeout; the block waits indefinitely.
  - Adder_ack outside ADD_WAIT is ignored.
- Iteration end:
  - After the shift on which count reaches ITER, go to DONE.
  - Otherwise return to RECODE.
- DONE:
  - res = {A,Q}[2*WIDTH-1:0], registered on entry.
  - BACK=1 for this single cycle; next edge goes to IDLE with busy=0.
  - A BREQ sampled on the DONE→IDLE edge is not accepted; the earliest accept is the following edge.
- Latency, with BREQ accepted at edge 0:
  - Each zero-digit iteration takes 1 edge.
  - Each nonzero iteration takes 1 edge plus k edges, where k ≥ 1 is the number of edges until ack is sampled.
  - With all-zero digits, BACK is high in the cycle after edge ITER (edge 13 at default).
- Width rule: AW holds A ± 2M without overflow for all extended inputs. Product bits above 2*WIDTH are discarded; they are redundant sign or zero bits.

Decomposition:
- Package booth_pkg:
  - enum BoothR4State {R4_Idle, R4_Recode, R4_AddWait, R4_Done}.
  - Booth digit encoding constants (ZERO, PM1, PM2, NM1, NM2).
- One combinational sub-module, booth_r4_recode: inputs {Q[1:0],Q1} and M; outputs the digit code and the AW-bit operand.
- The FSM and datapath stay in booth_r4_mult.

Test Plan:
- Default WIDTH=24, adder model acks 1 cycle after valid. Signed 3 × −5 gives res = 48'hFFFF_FFFF_FFF1, res_exc = 0, BACK a single cycle.
- Unsigned 24'hFFFFFF × 24'hFFFFFF gives res = 48'hFFFF_FE00_0001. The same operands signed (−1 × −1) give res = 48'h0000_0000_0001.
- m2 = 0: Adder_valid never asserts; BACK is high exactly in the cycle after edge 13 following acceptance; res = 0.
- Adder acks after 4 cycles with Adder_Exc = 2'b01 on one ack. Adder_valid and data stay stable throughout the wait; the product is still correct; res_exc = 2'b01.
- RSTK pulsed while in ADD_WAIT:
  - Adder_valid, busy, BACK and res are immediately 0.
  - No BACK follows.
  - A fresh BREQ with 7 × 6 gives res = 42.
- BREQ held high continuously: the second operation starts one edge after DONE, and no operand change during busy affects res. Also run WIDTH=8 signed −128 × −128, which gives res = 16'h4000.
